cv32e40p_apu_arbiter: RTL and testbench
=======================================

Name: cv32e40p_apu_arbiter

Overview:
- Shares one APU port between NB_REQ core-side dispatchers. Sits between the per-core APU dispatchers and the shared FPU/APU interconnect.
- Arbitrates requests round-robin and muxes the winner's payload to the APU.
- Records the winner's ID in an in-order tag FIFO so each returning result (apu_rvalid_i) is steered to the requester that issued it.

Parameters:
- NB_REQ, 4, number of requesters (2..8).
- PAYLOAD_W, 96, width of the request payload (operands, op, flags), passed through unmodified.
- RESULT_W, 32, width of the result bus, broadcast to all requesters.
- DEPTH, 4, maximum outstanding accepted-but-unreturned operations (power of 2, ≥2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  NB_REQ  per-requester request; held high with stable payload until its gnt_o
- payload_i  in  NB_REQ*PAYLOAD_W  per-requester payload; slot i = bits [i*PAYLOAD_W +: PAYLOAD_W]
- gnt_o  out  NB_REQ  one-hot grant; the request is accepted in this cycle
- rvalid_o  out  NB_REQ  one-hot result-valid for the owning requester
- result_o  out  RESULT_W  apu_result_i passed through to all requesters
- apu_req_o  out  1  request to the shared APU
- apu_payload_o  out  PAYLOAD_W  payload of the current winner
- apu_gnt_i  in  1  APU accepts apu_req_o this cycle
- apu_rvalid_i  in  1  APU returns one result (in issue order)
- apu_result_i  in  RESULT_W  APU result
- outstanding_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- full_o  out  1  outstanding_o == DEPTH
- err_o  out  1  sticky: apu_rvalid_i seen while the FIFO was empty
- arb_stall_cnt_o  out  32  cycles with at least one losing requester (see Optional Feature)

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - RR pointer = 0; FIFO empty; outstanding_o = 0; err_o = 0; counter = 0.
  - All outputs derived from this state are therefore 0, including gnt_o, rvalid_o, apu_req_o and full_o.
- Arbitration (combinational):
  - Winner = first i with req_i[i]=1, searching ptr, ptr+1, …, NB_REQ-1, 0, … (wrap-around).
  - apu_payload_o = payload of the winner; = 0 if there is no request.
- Issue:
  - apu_req_o = |req_i & !full_o.
  - gnt_o[winner] = apu_req_o & apu_gnt_i. All other gnt_o bits are 0.
- Accept (gnt_o nonzero):
  - Push winner ID into the FIFO.
  - ptr <= winner+1 mod NB_REQ.
  - If apu_gnt_i=0, the pointer holds, and the winner may change next cycle if req_i changes.
- Full:
  - When full_o=1, no request is issued, even if apu_rvalid_i pops in the same cycle. A freed slot is usable the next cycle. No combinational path from apu_rvalid_i to apu_req_o.
- Return (apu_rvalid_i=1 and FIFO non-empty):
  - rvalid_o[head ID] = 1 in the same cycle (zero latency); pop the head.
  - result_o = apu_result_i, unconditionally.
- Return with FIFO empty:
  - rvalid_o stays 0, nothing is popped, err_o <= 1 (sticky until reset).
  - Exception: a same-cycle grant does not satisfy it. The pushed entry is not visible until the next cycle.
- Simultaneous push and pop:
  - Occupancy unchanged; both pointers advance.
  - Pop uses the old head, so the push ID is not returned in the same cycle.
- FIFO pointers: $clog2(DEPTH) bits, wrap naturally; occupancy tracked separately, range 0..DEPTH.
- Reset mid-operation: in-flight tags are discarded. Results arriving after reset set err_o.

Optional Feature:
- Macro: CV32E40P_APU_ARB_STALL_CNT_EN.
- Defined:
  - 32-bit counter increments each cycle where popcount(req_i) ≥ 2, or (|req_i & full_o).
  - Saturates at 0xFFFF_FFFF; cleared by rst_i.
  - arb_stall_cnt_o = counter value.
- Undefined: no counter logic; arb_stall_cnt_o tied to 0.

Test Plan:
- Single requester: req_i=4'b0010, apu_gnt_i=1 for 1 cycle, apu_rvalid_i 3 cycles later.
  - gnt_o=4'b0010 that cycle; rvalid_o=4'b0010 on the return cycle; outstanding_o goes 1→0.
- Round-robin: req_i=4'b1111 held, apu_gnt_i=1 continuously, DEPTH=4, no returns.
  - gnt_o = 0001, 0010, 0100, 1000 over 4 cycles, then apu_req_o=0 with full_o=1.
  - With the macro defined, arb_stall_cnt_o increments every one of those cycles.
- In-order steering: grants to IDs 2, 0, 3, then 3 returns.
  - rvalid_o = 0100, 0001, 1000 in that order; result_o equals apu_result_i each cycle.
- Full plus simultaneous return: FIFO full, apu_rvalid_i=1, req_i=0001.
  - No grant that cycle; the grant issues the next cycle; outstanding_o goes 4→3→4.
- Push/pop same cycle at occupancy 1: grant ID1 while returning ID0.
  - rvalid_o=0001, outstanding_o stays 1, and the next return goes to ID1.
- Spurious return and reset: apu_rvalid_i=1 with the FIFO empty.
  - err_o=1 next cycle and rvalid_o=0. Assert rst_i mid-traffic: everything is 0 the next cycle and err_o clears.

Source files
------------

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU port between NB_REQ dispatchers, with an in-order
// tag FIFO steering results back. Optional stall counter: CV32E40P_APU_ARB_STALL_CNT_EN.
module cv32e40p_apu_arbiter #(
   parameter int unsigned NB_REQ    = 4,
   parameter int unsigned PAYLOAD_W = 96,
   parameter int unsigned RESULT_W  = 32,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NB_REQ-1:0]             req_i,
   input  logic [NB_REQ*PAYLOAD_W-1:0]   payload_i,
   output logic [NB_REQ-1:0]             gnt_o,
   output logic [NB_REQ-1:0]             rvalid_o,
   output logic [RESULT_W-1:0]           result_o,
   output logic                          apu_req_o,
   output logic [PAYLOAD_W-1:0]          apu_payload_o,
   input  logic                          apu_gnt_i,
   input  logic                          apu_rvalid_i,
   input  logic [RESULT_W-1:0]           apu_result_i,
   output logic [$clog2(DEPTH):0]        outstanding_o,
   output logic                          full_o,
   output logic                          err_o,
   output logic [31:0]                   arb_stall_cnt_o
);

   localparam int unsigned ID_W  = $clog2(NB_REQ);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NB_REQ - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  fifo_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q;

   logic [ID_W-1:0]  winner;
   logic [ID_W-1:0]  head_id;
   logic             any_req;
   logic             full;
   logic             push;
   logic             pop;

   // Wrap-around search starting at the round-robin pointer.
   always_comb begin
      int unsigned idx;
      logic        found;
      idx    = 0;
      found  = 1'b0;
      winner = rr_ptr_q;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
         idx = 32'(rr_ptr_q) + i;
         if (idx >= NB_REQ) idx = idx - NB_REQ;
         if (!found && req_i[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   assign any_req   = |req_i;
   assign full      = (cnt_q == FULL_CNT);
   assign apu_req_o = any_req & ~full;
   assign push      = apu_req_o & apu_gnt_i;
   assign pop       = apu_rvalid_i & (cnt_q != '0);
   assign head_id   = fifo_q[rd_ptr_q];

   assign apu_payload_o = any_req ? payload_i[winner*PAYLOAD_W +: PAYLOAD_W] : '0;
   assign result_o      = apu_result_i;
   assign outstanding_o = cnt_q;
   assign full_o        = full;
   assign err_o         = err_q;

   always_comb begin
      gnt_o    = '0;
      rvalid_o = '0;
      if (push) gnt_o[winner]   = 1'b1;
      if (pop)  rvalid_o[head_id] = 1'b1;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (push) rr_ptr_d = (winner == LAST_ID) ? '0 : winner + 1'b1;
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= winner;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         // A same-cycle push does not satisfy a return: occupancy is checked before the push.
         if (apu_rvalid_i && (cnt_q == '0)) err_q <= 1'b1;
      end
   end

`ifdef CV32E40P_APU_ARB_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   logic        stall;

   always_comb begin
      int unsigned nreq;
      nreq = 0;
      for (int unsigned i = 0; i < NB_REQ; i++) nreq = nreq + 32'(req_i[i]);
      stall = (nreq >= 2) || (any_req && full);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)                              stall_cnt_q <= '0;
      else if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 1'b1;
   end

   assign arb_stall_cnt_o = stall_cnt_q;
`else
   assign arb_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed self-checking bench for cv32e40p_apu_arbiter (NB_REQ=4, DEPTH=4).
module tb_cv32e40p_apu_arbiter;

   localparam int unsigned NB_REQ    = 4;
   localparam int unsigned PAYLOAD_W = 96;
   localparam int unsigned RESULT_W  = 32;
   localparam int unsigned DEPTH     = 4;

   logic                        clk_i = 1'b0;
   logic                        rst_i;
   logic [NB_REQ-1:0]           req_i;
   logic [NB_REQ*PAYLOAD_W-1:0] payload_i;
   logic [NB_REQ-1:0]           gnt_o;
   logic [NB_REQ-1:0]           rvalid_o;
   logic [RESULT_W-1:0]         result_o;
   logic                        apu_req_o;
   logic [PAYLOAD_W-1:0]        apu_payload_o;
   logic                        apu_gnt_i;
   logic                        apu_rvalid_i;
   logic [RESULT_W-1:0]         apu_result_i;
   logic [2:0]                  outstanding_o;
   logic                        full_o;
   logic                        err_o;
   logic [31:0]                 arb_stall_cnt_o;

   int checks = 0;
   int errors = 0;

   cv32e40p_apu_arbiter #(
      .NB_REQ   (NB_REQ),
      .PAYLOAD_W(PAYLOAD_W),
      .RESULT_W (RESULT_W),
      .DEPTH    (DEPTH)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .payload_i      (payload_i),
      .gnt_o          (gnt_o),
      .rvalid_o       (rvalid_o),
      .result_o       (result_o),
      .apu_req_o      (apu_req_o),
      .apu_payload_o  (apu_payload_o),
      .apu_gnt_i      (apu_gnt_i),
      .apu_rvalid_i   (apu_rvalid_i),
      .apu_result_i   (apu_result_i),
      .outstanding_o  (outstanding_o),
      .full_o         (full_o),
      .err_o          (err_o),
      .arb_stall_cnt_o(arb_stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i        = 1'b1;
      req_i        = '0;
      apu_gnt_i    = 1'b0;
      apu_rvalid_i = 1'b0;
      tick();
      rst_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_i        = 1'b1;
      req_i        = 4'b1011;
      apu_gnt_i    = 1'b1;
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'hDEAD_BEEF;
      tick();
      rst_i        = 1'b0;
      req_i        = '0;
      apu_gnt_i    = 1'b0;
      apu_rvalid_i = 1'b0;
      #1;
      checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt_o); end
      checks++; if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid_o); end
      checks++; if (apu_req_o !== 1'b0) begin errors++; $display("FAIL reset_apu_req got=%b exp=0", apu_req_o); end
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); end
      checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
      checks++; if (apu_payload_o !== 96'h0) begin errors++; $display("FAIL reset_payload got=%h exp=0", apu_payload_o); end
      checks++; if (arb_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", arb_stall_cnt_o); end
   endtask

   task automatic test_single();
      req_i     = 4'b0010;
      apu_gnt_i = 1'b1;
      #1;
      checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL single_gnt got=%b exp=0010", gnt_o); end
      checks++; if (apu_payload_o !== {3{32'hC0DE_0001}}) begin errors++; $display("FAIL single_payload got=%h exp=%h", apu_payload_o, {3{32'hC0DE_0001}}); end
      tick();
      req_i     = '0;
      apu_gnt_i = 1'b0;
      #1;
      checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL single_outstanding1 got=%0d exp=1", outstanding_o); end
      checks++; if (apu_payload_o !== 96'h0) begin errors++; $display("FAIL single_idle_payload got=%h exp=0", apu_payload_o); end
      tick();
      tick();
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'h1234_5678;
      #1;
      checks++; if (rvalid_o !== 4'b0010) begin errors++; $display("FAIL single_rvalid got=%b exp=0010", rvalid_o); end
      checks++; if (result_o !== 32'h1234_5678) begin errors++; $display("FAIL single_result got=%h exp=12345678", result_o); end
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL single_outstanding0 got=%0d exp=0", outstanding_o); end
      checks++; if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL single_rvalid_clr got=%b exp=0000", rvalid_o); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt [4];
      exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100; exp_gnt[3] = 4'b1000;
      do_reset();
      req_i     = 4'b1111;
      apu_gnt_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (gnt_o !== exp_gnt[k]) begin errors++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt_o, exp_gnt[k]); end
         checks++; if (apu_payload_o !== {3{32'hC0DE_0000 | k}}) begin errors++; $display("FAIL rr_payload%0d got=%h", k, apu_payload_o); end
         tick();
      end
      checks++; if (apu_req_o !== 1'b0) begin errors++; $display("FAIL rr_full_apu_req got=%b exp=0", apu_req_o); end
      checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL rr_full got=%b exp=1", full_o); end
      checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL rr_full_gnt got=%b exp=0000", gnt_o); end
      checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL rr_outstanding got=%0d exp=4", outstanding_o); end
`ifdef CV32E40P_APU_ARB_STALL_CNT_EN
      checks++; if (arb_stall_cnt_o !== 32'd4) begin errors++; $display("FAIL rr_stall_cnt got=%0d exp=4", arb_stall_cnt_o); end
`else
      checks++; if (arb_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL rr_stall_cnt got=%0d exp=0", arb_stall_cnt_o); end
`endif
   endtask

   task automatic test_full_return();
      logic [3:0] exp_rv [4];
      exp_rv[0] = 4'b0010; exp_rv[1] = 4'b0100; exp_rv[2] = 4'b1000; exp_rv[3] = 4'b0001;
      req_i        = 4'b0001;
      apu_gnt_i    = 1'b1;
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'hAAAA_0000;
      #1;
      checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL full_ret_gnt got=%b exp=0000", gnt_o); end
      checks++; if (apu_req_o !== 1'b0) begin errors++; $display("FAIL full_ret_apu_req got=%b exp=0", apu_req_o); end
      checks++; if (rvalid_o !== 4'b0001) begin errors++; $display("FAIL full_ret_rvalid got=%b exp=0001", rvalid_o); end
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      checks++; if (outstanding_o !== 3'd3) begin errors++; $display("FAIL full_ret_occ3 got=%0d exp=3", outstanding_o); end
      checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL full_ret_next_gnt got=%b exp=0001", gnt_o); end
`ifdef CV32E40P_APU_ARB_STALL_CNT_EN
      checks++; if (arb_stall_cnt_o !== 32'd5) begin errors++; $display("FAIL full_ret_stall_cnt got=%0d exp=5", arb_stall_cnt_o); end
`endif
      tick();
      req_i     = '0;
      apu_gnt_i = 1'b0;
      #1;
      checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL full_ret_occ4 got=%0d exp=4", outstanding_o); end
      apu_rvalid_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         apu_result_i = 32'h5000 + k;
         #1;
         checks++; if (rvalid_o !== exp_rv[k]) begin errors++; $display("FAIL drain_rvalid%0d got=%b exp=%b", k, rvalid_o, exp_rv[k]); end
         tick();
      end
      apu_rvalid_i = 1'b0;
      #1;
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL drain_empty got=%0d exp=0", outstanding_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL drain_err got=%b exp=0", err_o); end
   endtask

   task automatic test_in_order();
      logic [3:0]  reqs   [3];
      logic [3:0]  exp_rv [3];
      logic [31:0] res    [3];
      reqs[0] = 4'b0100; reqs[1] = 4'b0001; reqs[2] = 4'b1000;
      exp_rv[0] = 4'b0100; exp_rv[1] = 4'b0001; exp_rv[2] = 4'b1000;
      res[0] = 32'h0000_00A2; res[1] = 32'h0000_00B0; res[2] = 32'h0000_00C3;
      apu_gnt_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_i = reqs[k];
         #1;
         checks++; if (gnt_o !== reqs[k]) begin errors++; $display("FAIL order_gnt%0d got=%b exp=%b", k, gnt_o, reqs[k]); end
         tick();
      end
      req_i        = '0;
      apu_gnt_i    = 1'b0;
      apu_rvalid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         apu_result_i = res[k];
         #1;
         checks++; if (rvalid_o !== exp_rv[k]) begin errors++; $display("FAIL order_rvalid%0d got=%b exp=%b", k, rvalid_o, exp_rv[k]); end
         checks++; if (result_o !== res[k]) begin errors++; $display("FAIL order_result%0d got=%h exp=%h", k, result_o, res[k]); end
         tick();
      end
      apu_rvalid_i = 1'b0;
      #1;
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL order_empty got=%0d exp=0", outstanding_o); end
   endtask

   task automatic test_push_pop();
      req_i     = 4'b0001;
      apu_gnt_i = 1'b1;
      tick();
      req_i        = 4'b0010;
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'h0000_0111;
      #1;
      checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL pp_gnt got=%b exp=0010", gnt_o); end
      checks++; if (rvalid_o !== 4'b0001) begin errors++; $display("FAIL pp_rvalid got=%b exp=0001", rvalid_o); end
      tick();
      req_i     = '0;
      apu_gnt_i = 1'b0;
      #1;
      checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL pp_occ got=%0d exp=1", outstanding_o); end
      checks++; if (rvalid_o !== 4'b0010) begin errors++; $display("FAIL pp_next_rvalid got=%b exp=0010", rvalid_o); end
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL pp_empty got=%0d exp=0", outstanding_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL pp_err got=%b exp=0", err_o); end
   endtask

   task automatic test_spurious_reset();
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'h0000_0BAD;
      #1;
      checks++; if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL spur_rvalid got=%b exp=0000", rvalid_o); end
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err got=%b exp=1", err_o); end
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL spur_occ got=%0d exp=0", outstanding_o); end
      // A grant in the same cycle as a return on an empty FIFO must not satisfy it.
      req_i        = 4'b0001;
      apu_gnt_i    = 1'b1;
      apu_rvalid_i = 1'b1;
      #1;
      checks++; if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL samecyc_rvalid got=%b exp=0000", rvalid_o); end
      checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL samecyc_gnt got=%b exp=0001", gnt_o); end
      tick();
      apu_rvalid_i = 1'b0;
      req_i        = 4'b1111;
      #1;
      checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL samecyc_occ got=%0d exp=1", outstanding_o); end
      tick();
      rst_i = 1'b1;
      tick();
      rst_i     = 1'b0;
      req_i     = '0;
      apu_gnt_i = 1'b0;
      #1;
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL midrst_occ got=%0d exp=0", outstanding_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", err_o); end
      checks++; if (gnt_o !== 4'b0000 || rvalid_o !== 4'b0000 || full_o !== 1'b0 || apu_req_o !== 1'b0) begin
         errors++; $display("FAIL midrst_outputs gnt=%b rvalid=%b full=%b apu_req=%b exp all 0", gnt_o, rvalid_o, full_o, apu_req_o);
      end
      checks++; if (arb_stall_cnt_o !== 32'd0) begin errors++; $display("FAIL midrst_stall_cnt got=%0d exp=0", arb_stall_cnt_o); end
      apu_rvalid_i = 1'b1;
      #1;
      checks++; if (rvalid_o !== 4'b0000) begin errors++; $display("FAIL postrst_rvalid got=%b exp=0000", rvalid_o); end
      tick();
      apu_rvalid_i = 1'b0;
      #1;
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL postrst_err got=%b exp=1", err_o); end
   endtask

   initial begin
      rst_i        = 1'b1;
      req_i        = '0;
      apu_gnt_i    = 1'b0;
      apu_rvalid_i = 1'b0;
      apu_result_i = '0;
      for (int i = 0; i < NB_REQ; i++) payload_i[i*PAYLOAD_W +: PAYLOAD_W] = {3{32'hC0DE_0000 | i}};
      test_reset();
      test_single();
      test_round_robin();
      test_full_return();
      test_in_order();
      test_push_pop();
      test_spurious_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule
